deser1_32: RTL and testbench
============================

DESER1_32 -- requirements
Module: deser1_32

Interface
REQ-001 Clock  input  1  sole clock; all state changes on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 Enable  input  1  serial bit strobe; Data0 is sampled when Enable=1 and Ready=1.
REQ-004 Data0  input  1  serial data bit.
REQ-005 Ack  input  1  consumer acknowledge of the held parallel word.
REQ-006 Result0..Result31  output  1 each  parallel word; Result0 = first bit received.
REQ-007 Valid  output  1  parallel word complete and held.
REQ-008 Ready  output  1  block accepts serial bits.
REQ-009 Count0..Count4  output  1 each  bits received in the current word, Count0 = LSB.
REQ-010 Overrun  output  1  sticky flag: a bit was offered while the word was held.

Function
REQ-011 The state machine SHALL have two states: FILL (Ready=1, Valid=0) and FULL (Ready=0, Valid=1).
REQ-012 In FILL with Enable=1, the block SHALL write Data0 into internal shadow bit position {Count4..Count0} and increment Count by 1 at the same edge.
REQ-013 In FILL with Enable=0, the shadow register and Count SHALL hold.
REQ-014 The accept that makes Count wrap from 31 to 0 SHALL copy all 32 shadow bits, including the bit accepted at that edge, to Result0..Result31 at that same edge and enter FULL, so Valid=1 in the cycle after the 32nd accept.
REQ-015 Result0..Result31 SHALL change only on the transition into FULL and SHALL be stable at all other times, including during FILL of the next word.
REQ-016 In FULL with Ack=1, the next state SHALL be FILL, with Valid=0 and Ready=1 from the next cycle; Result SHALL hold its value.
REQ-017 In FULL with Ack=0, the state SHALL stay FULL indefinitely.
REQ-018 In FULL with Enable=1, the bit SHALL be discarded, Count SHALL not change, and Overrun SHALL be set to 1 at that edge.
REQ-019 With Ack=1 and Enable=1 in the same FULL cycle, the block SHALL accept Ack, discard the bit, and set Overrun.
REQ-020 Ack in FILL SHALL be ignored.
REQ-021 Overrun SHALL be cleared only by Reset.
REQ-022 Count SHALL be 0 whenever the state is FULL.
REQ-023 Back-to-back operation SHALL be supported: an Ack cycle followed immediately by 32 consecutive Enable cycles produces the next word, with no dead cycle beyond the Ack cycle.

Reset
REQ-024 Reset=1 at a rising edge SHALL force:
- state = FILL, Ready=1, Valid=0
- Count = 0
- Overrun = 0
- Result0..Result31 = 0
- shadow register = 0
REQ-025 Reset SHALL take priority over Enable and Ack in the same cycle.
REQ-026 Reset mid-word (0 < Count < 32) SHALL discard the partial word.
REQ-027 After Reset deasserts, the first accepted bit SHALL land in position 0.

Verification
REQ-028 Reset, then 32 consecutive Enable cycles carrying 0xA5A50F0F LSB first -> Valid=1 one cycle after the 32nd bit; {Result31..Result0}=0xA5A50F0F; Count=0; Ready=0.
REQ-029 Word in FULL, Ack=1 for one cycle -> next cycle Valid=0, Ready=1, Result still 0xA5A50F0F; then 32 bits of 0x12345678 -> Result=0x12345678, Result unchanged during that fill.
REQ-030 Deliver 16 bits with Enable gapped (Enable=1 every other cycle), then 16 contiguous bits -> Count reads 16 after the 16th accept; final Result is correct; Valid asserts exactly once.
REQ-031 In FULL, hold Ack=0 and pulse Enable=1 three times -> Overrun=1, Count=0, Result unchanged; Ack, then a new 32-bit word -> correct word, Overrun stays 1 until Reset.
REQ-032 Reset asserted after 20 accepted bits, then 32 bits of 0xFFFFFFFF -> Result=0xFFFFFFFF, with Valid asserting only after the 32 post-reset bits.
REQ-033 Ack=1 and Enable=1 together in FULL -> next cycle FILL, Count=0, Overrun=1; the offered bit does not appear in the next word.

Source files
------------

// File: rtl/deser1_32.sv
`default_nettype none
// ============================================================================
//  Module      : deser1_32
//  Description : 1-to-32 serial-to-parallel deserializer. Serial bits fill a
//                shadow register and each completed word is copied into a held
//                parallel output that stays until the consumer acknowledges it.
//                A sticky flag records bits offered while a word is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module deser1_32 (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    input  logic Data0,
    input  logic Ack,
    output logic Result0,  output logic Result1,  output logic Result2,  output logic Result3,
    output logic Result4,  output logic Result5,  output logic Result6,  output logic Result7,
    output logic Result8,  output logic Result9,  output logic Result10, output logic Result11,
    output logic Result12, output logic Result13, output logic Result14, output logic Result15,
    output logic Result16, output logic Result17, output logic Result18, output logic Result19,
    output logic Result20, output logic Result21, output logic Result22, output logic Result23,
    output logic Result24, output logic Result25, output logic Result26, output logic Result27,
    output logic Result28, output logic Result29, output logic Result30, output logic Result31,
    output logic Valid,
    output logic Ready,
    output logic Count0,
    output logic Count1,
    output logic Count2,
    output logic Count3,
    output logic Count4,
    output logic Overrun
);

    localparam logic [0:0] c_fill = 1'b0;
    localparam logic [0:0] c_full = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [31:0] r_shadow;
    logic [31:0] w_shadow_next;
    logic [31:0] r_result;
    logic [4:0]  r_count;
    logic        r_overrun;
    logic        w_accept;
    logic        w_discard;
    logic        w_last_bit;
    logic        w_ready;
    logic        w_valid;

    // A bit is taken only while filling; a bit offered while holding is lost
    assign w_accept   = Enable & (r_state == c_fill);
    assign w_discard  = Enable & (r_state == c_full);
    assign w_last_bit = (r_count == 5'd31);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_fill;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: the 32nd accept fills the word, Ack releases it
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_fill:  if (w_accept && w_last_bit) w_next_state = c_full;
            c_full:  if (Ack) w_next_state = c_fill;
            default: w_next_state = c_fill;
        endcase
    end

    // Output decode of the handshake flags from the state
    always_comb begin
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            c_fill:  w_ready = 1'b1;
            c_full:  w_valid = 1'b1;
            default: w_ready = 1'b1;
        endcase
    end

    // Shadow image with the incoming bit merged at the current position, so
    // the final accept can copy a complete word in the same edge
    always_comb begin
        w_shadow_next          = r_shadow;
        w_shadow_next[r_count] = Data0;
    end

    // Datapath: shadow fill, bit counter, held word and sticky overrun flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_shadow  <= 32'd0;
            r_count   <= 5'd0;
            r_result  <= 32'd0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shadow <= w_shadow_next;
                r_count  <= r_count + 5'd1;   // wraps 31 -> 0 as FULL is entered
                if (w_last_bit) begin
                    r_result <= w_shadow_next;
                end
            end
            if (w_discard) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign Ready   = w_ready;
    assign Valid   = w_valid;
    assign Overrun = r_overrun;

    assign Count0 = r_count[0];
    assign Count1 = r_count[1];
    assign Count2 = r_count[2];
    assign Count3 = r_count[3];
    assign Count4 = r_count[4];

    assign Result0  = r_result[0];   assign Result1  = r_result[1];
    assign Result2  = r_result[2];   assign Result3  = r_result[3];
    assign Result4  = r_result[4];   assign Result5  = r_result[5];
    assign Result6  = r_result[6];   assign Result7  = r_result[7];
    assign Result8  = r_result[8];   assign Result9  = r_result[9];
    assign Result10 = r_result[10];  assign Result11 = r_result[11];
    assign Result12 = r_result[12];  assign Result13 = r_result[13];
    assign Result14 = r_result[14];  assign Result15 = r_result[15];
    assign Result16 = r_result[16];  assign Result17 = r_result[17];
    assign Result18 = r_result[18];  assign Result19 = r_result[19];
    assign Result20 = r_result[20];  assign Result21 = r_result[21];
    assign Result22 = r_result[22];  assign Result23 = r_result[23];
    assign Result24 = r_result[24];  assign Result25 = r_result[25];
    assign Result26 = r_result[26];  assign Result27 = r_result[27];
    assign Result28 = r_result[28];  assign Result29 = r_result[29];
    assign Result30 = r_result[30];  assign Result31 = r_result[31];

endmodule
`default_nettype wire

// File: tb/tb_deser1_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deser1_32
//  Description : Directed self-checking bench for deser1_32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deser1_32;

    logic Clock = 1'b0;
    logic Reset, Enable, Data0, Ack;
    logic Valid, Ready, Overrun;
    logic Count0, Count1, Count2, Count3, Count4;
    logic Result0,  Result1,  Result2,  Result3,  Result4,  Result5,  Result6,  Result7;
    logic Result8,  Result9,  Result10, Result11, Result12, Result13, Result14, Result15;
    logic Result16, Result17, Result18, Result19, Result20, Result21, Result22, Result23;
    logic Result24, Result25, Result26, Result27, Result28, Result29, Result30, Result31;

    logic [31:0] w_result;
    logic [4:0]  w_count;

    int n_tests  = 0;
    int n_failed = 0;
    int valid_hits = 0;

    assign w_result = {Result31, Result30, Result29, Result28, Result27, Result26, Result25, Result24,
                       Result23, Result22, Result21, Result20, Result19, Result18, Result17, Result16,
                       Result15, Result14, Result13, Result12, Result11, Result10, Result9,  Result8,
                       Result7,  Result6,  Result5,  Result4,  Result3,  Result2,  Result1,  Result0};
    assign w_count  = {Count4, Count3, Count2, Count1, Count0};

    always #5 Clock = ~Clock;

    deser1_32 u_dut (
        .Clock   (Clock),   .Reset   (Reset),   .Enable  (Enable),
        .Data0   (Data0),   .Ack     (Ack),
        .Result0 (Result0), .Result1 (Result1), .Result2 (Result2), .Result3 (Result3),
        .Result4 (Result4), .Result5 (Result5), .Result6 (Result6), .Result7 (Result7),
        .Result8 (Result8), .Result9 (Result9), .Result10(Result10), .Result11(Result11),
        .Result12(Result12), .Result13(Result13), .Result14(Result14), .Result15(Result15),
        .Result16(Result16), .Result17(Result17), .Result18(Result18), .Result19(Result19),
        .Result20(Result20), .Result21(Result21), .Result22(Result22), .Result23(Result23),
        .Result24(Result24), .Result25(Result25), .Result26(Result26), .Result27(Result27),
        .Result28(Result28), .Result29(Result29), .Result30(Result30), .Result31(Result31),
        .Valid   (Valid),   .Ready   (Ready),
        .Count0  (Count0),  .Count1  (Count1),  .Count2  (Count2),  .Count3  (Count3),
        .Count4  (Count4),  .Overrun (Overrun)
    );

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge Clock);
        #1;
        if (Valid === 1'b1) valid_hits++;
    endtask

    // Present 32 contiguous bits LSB first
    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            Enable = 1'b1;
            Data0  = w[i];
            step();
        end
        Enable = 1'b0;
        Data0  = 1'b0;
    endtask

    task automatic do_ack();
        Ack = 1'b1;
        step();
        Ack = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; Data0 = 1'b0; Ack = 1'b0;
        step();
        step();
        Reset = 1'b0;

        // Reset state
        check("rst_valid",   {31'd0, Valid},   32'd0);
        check("rst_ready",   {31'd0, Ready},   32'd1);
        check("rst_count",   {27'd0, w_count}, 32'd0);
        check("rst_overrun", {31'd0, Overrun}, 32'd0);
        check("rst_result",  w_result,         32'd0);

        // First word, contiguous; Valid must still be low after 31 bits
        for (int i = 0; i < 31; i++) begin
            Enable = 1'b1; Data0 = (32'hA5A50F0F >> i) & 1; step();
        end
        check("w1_valid_at31", {31'd0, Valid}, 32'd0);
        check("w1_count_at31", {27'd0, w_count}, 32'd31);
        Data0 = 1'b1; step();     // bit 31 of 0xA5A50F0F is 1
        Enable = 1'b0; Data0 = 1'b0;
        check("w1_valid",  {31'd0, Valid}, 32'd1);
        check("w1_ready",  {31'd0, Ready}, 32'd0);
        check("w1_count",  {27'd0, w_count}, 32'd0);
        check("w1_result", w_result, 32'hA5A50F0F);

        // FULL holds without Ack
        step(); step();
        check("w1_hold_valid", {31'd0, Valid}, 32'd1);

        // Ack releases; Result holds
        do_ack();
        check("ack_valid",  {31'd0, Valid}, 32'd0);
        check("ack_ready",  {31'd0, Ready}, 32'd1);
        check("ack_result", w_result, 32'hA5A50F0F);

        // Second word, Ack held high in FILL for the first 16 bits (ignored)
        Ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Enable = 1'b1; Data0 = (32'h12345678 >> i) & 1; step();
        end
        Ack = 1'b0;
        check("w2_mid_count",  {27'd0, w_count}, 32'd16);
        check("w2_mid_result", w_result, 32'hA5A50F0F);
        for (int i = 16; i < 32; i++) begin
            Enable = 1'b1; Data0 = (32'h12345678 >> i) & 1; step();
        end
        Enable = 1'b0; Data0 = 1'b0;
        check("w2_valid",  {31'd0, Valid}, 32'd1);
        check("w2_result", w_result, 32'h12345678);

        // Gapped 16 bits then 16 contiguous; Valid seen on exactly one sample
        do_ack();
        valid_hits = 0;
        for (int i = 0; i < 16; i++) begin
            Enable = 1'b1; Data0 = (32'hCAFEBABE >> i) & 1; step();
            if (i == 15) check("gap_count16", {27'd0, w_count}, 32'd16);
            Enable = 1'b0; Data0 = 1'b0; step();
        end
        for (int i = 16; i < 32; i++) begin
            Enable = 1'b1; Data0 = (32'hCAFEBABE >> i) & 1; step();
        end
        Enable = 1'b0; Data0 = 1'b0;
        check("gap_result",     w_result, 32'hCAFEBABE);
        check("gap_valid_once", valid_hits, 32'd1);

        // Overrun: three bits offered while held
        for (int i = 0; i < 3; i++) begin
            Enable = 1'b1; Data0 = 1'b1; step();
            Enable = 1'b0; Data0 = 1'b0; step();
        end
        check("ovr_flag",   {31'd0, Overrun}, 32'd1);
        check("ovr_count",  {27'd0, w_count}, 32'd0);
        check("ovr_result", w_result, 32'hCAFEBABE);
        check("ovr_valid",  {31'd0, Valid}, 32'd1);
        do_ack();
        send_word(32'h0F0F1234);
        check("ovr_next_result", w_result, 32'h0F0F1234);
        check("ovr_sticky",      {31'd0, Overrun}, 32'd1);

        // Reset after 20 accepted bits, with Enable asserted alongside Reset
        do_ack();
        for (int i = 0; i < 20; i++) begin
            Enable = 1'b1; Data0 = 1'b1; step();
        end
        Reset = 1'b1; Enable = 1'b1; Data0 = 1'b1; step();
        Reset = 1'b0; Enable = 1'b0; Data0 = 1'b0;
        check("mrst_count",   {27'd0, w_count}, 32'd0);
        check("mrst_overrun", {31'd0, Overrun}, 32'd0);
        check("mrst_result",  w_result, 32'd0);
        for (int i = 0; i < 31; i++) begin
            Enable = 1'b1; Data0 = 1'b1; step();
        end
        check("mrst_valid_at31", {31'd0, Valid}, 32'd0);
        step();
        Enable = 1'b0; Data0 = 1'b0;
        check("mrst_valid",  {31'd0, Valid}, 32'd1);
        check("mrst_result2", w_result, 32'hFFFFFFFF);

        // Ack and Enable together in FULL: bit dropped, Overrun set
        Ack = 1'b1; Enable = 1'b1; Data0 = 1'b1; step();
        Ack = 1'b0; Enable = 1'b0; Data0 = 1'b0;
        check("ae_valid",   {31'd0, Valid},   32'd0);
        check("ae_ready",   {31'd0, Ready},   32'd1);
        check("ae_count",   {27'd0, w_count}, 32'd0);
        check("ae_overrun", {31'd0, Overrun}, 32'd1);
        send_word(32'h00000000);
        check("ae_result", w_result, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
`default_nettype wire
